// File: rtl/nat_pkg.sv
// nat_pkg: shared tuple layout, protocol constants and parser types for the NAT path
package nat_pkg;
   localparam int TUPLE_W   = 104;
   localparam int PROTO_LSB = 0;
   localparam int PROTO_W   = 8;
   localparam int DPORT_LSB = 8;
   localparam int SPORT_LSB = 24;
   localparam int PORT_W    = 16;
   localparam int DIP_LSB   = 40;
   localparam int SIP_LSB   = 72;
   localparam int IP_W      = 32;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  PROTO_TCP      = 8'd6;
   localparam logic [7:0]  PROTO_UDP      = 8'd17;
   localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
   typedef enum logic {HDR, SKIP} parse_state_t;
   function automatic logic [7:0] lane(input logic [63:0] d, input int n);
      return d[8*n +: 8];
   endfunction
endpackage

// File: rtl/tuple_extract_if.sv
// tuple_extract_if: packet tap stream in, extracted tuple stream out
interface tuple_extract_if;
   logic [63:0]  s_tdata;
   logic [7:0]   s_tkeep;
   logic         s_tvalid;
   logic         s_tlast;
   logic [127:0] tuple_data;
   logic         tuple_valid;
   logic         tuple_ready;
   modport master (output s_tdata, s_tkeep, s_tvalid, s_tlast, tuple_ready,
                   input tuple_data, tuple_valid);
   modport slave (input s_tdata, s_tkeep, s_tvalid, s_tlast, tuple_ready,
                  output tuple_data, tuple_valid);
endinterface

// File: rtl/tuple_fifo.sv
// tuple_fifo: small synchronous FIFO holding extracted tuples; head reads as zero when empty
module tuple_fifo #(
   parameter int WIDTH = 104,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = count == (AW+1)'(DEPTH);
   assign empty    = count == '0;
   assign pop_data = empty ? '0 : mem[rd_ptr];
   // storage write; contents need no reset since empty masks the head
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/tuple_extract.sv
// tuple_extract: passive tap parsing IPv4 TCP/UDP headers into 5-tuples for the connection table
module tuple_extract
   import nat_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   tuple_extract_if.slave tif,
   output logic [31:0]  stat_pkts,
   output logic [31:0]  stat_tuples,
   output logic [31:0]  stat_skipped,
   output logic [31:0]  stat_dropped
);
   parse_state_t       state;
   logic [2:0]         beat_idx;
   logic [7:0]         proto_q;
   logic [31:0]        sip_q;
   logic [15:0]        dip_hi_q;
   logic [63:0]        d;
   logic               acc, in_hdr, last_hdr, keep_ok, field_ok, beat_ok, fail, push, pop, push_ok;
   logic               full, empty;
   logic [TUPLE_W-1:0] tuple_in, tuple_out;
   assign d        = tif.s_tdata;
   assign acc      = tif.s_tvalid;
   assign in_hdr   = state == HDR;
   assign last_hdr = beat_idx == 3'd4;
   // per-beat header checks: Ethertype/version on beat 1, protocol and unfragmented on beat 2
   always_comb begin
      keep_ok  = last_hdr ? &tif.s_tkeep[5:0] : &tif.s_tkeep;
      field_ok = (beat_idx == 3'd1) ? ({lane(d, 4), lane(d, 5)} == ETHERTYPE_IPV4 && lane(d, 6) == IPV4_VER_IHL) :
                 (beat_idx == 3'd2) ? ((lane(d, 7) == PROTO_TCP || lane(d, 7) == PROTO_UDP) &&
                                       d[37:32] == 6'd0 && d[47:40] == 8'd0) : 1'b1;
   end
   assign beat_ok  = keep_ok && field_ok;
   assign fail     = acc && in_hdr && (!beat_ok || (tif.s_tlast && !last_hdr));
   assign push     = acc && in_hdr && last_hdr && beat_ok;
   assign pop      = tif.tuple_valid && tif.tuple_ready;
   assign push_ok  = push && (!full || pop);
   assign tuple_in = {sip_q, dip_hi_q, lane(d, 0), lane(d, 1), lane(d, 2), lane(d, 3),
                      lane(d, 4), lane(d, 5), proto_q};
   // header walker: advance through beats 0..4, bail to SKIP on any failure, resync on tlast
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= HDR;
         beat_idx <= '0;
         proto_q  <= '0;
         sip_q    <= '0;
         dip_hi_q <= '0;
      end else if (acc) begin
         if (!in_hdr) begin
            if (tif.s_tlast) state <= HDR;
         end else if (fail || last_hdr) begin
            state    <= tif.s_tlast ? HDR : SKIP;
            beat_idx <= '0;
         end else begin
            beat_idx <= beat_idx + 3'd1;
         end
         if (in_hdr && beat_idx == 3'd2) proto_q <= lane(d, 7);
         if (in_hdr && beat_idx == 3'd3) begin
            sip_q    <= {lane(d, 2), lane(d, 3), lane(d, 4), lane(d, 5)};
            dip_hi_q <= {lane(d, 6), lane(d, 7)};
         end
      end
   end
   // event counters; a push lost to a full FIFO counts as dropped, not as a tuple
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_pkts    <= '0;
         stat_tuples  <= '0;
         stat_skipped <= '0;
         stat_dropped <= '0;
      end else begin
         stat_pkts    <= stat_pkts + 32'(acc && tif.s_tlast);
         stat_tuples  <= stat_tuples + 32'(push_ok);
         stat_skipped <= stat_skipped + 32'(fail);
         stat_dropped <= stat_dropped + 32'(push && !push_ok);
      end
   end
   tuple_fifo #(.WIDTH(TUPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(tuple_in),
      .pop      (pop),
      .pop_data (tuple_out),
      .full     (full),
      .empty    (empty)
   );
   assign tif.tuple_valid = !empty;
   assign tif.tuple_data  = {24'b0, tuple_out};
endmodule

// File: tb/tb_tuple_extract.sv
// tb_tuple_extract: directed checks of header parsing, skipping, FIFO backpressure and reset
module tb_tuple_extract;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] stat_pkts, stat_tuples, stat_skipped, stat_dropped;
   logic [7:0]  fb [0:127];
   int          checks = 0;
   int          errors = 0;

   tuple_extract_if tif();

   tuple_extract #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .tif         (tif),
      .stat_pkts   (stat_pkts),
      .stat_tuples (stat_tuples),
      .stat_skipped(stat_skipped),
      .stat_dropped(stat_dropped)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] exp_tuple(input logic [31:0] sip, input logic [31:0] dip,
                                             input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr);
      return {24'b0, sip, dip, sp, dp, pr};
   endfunction

   task automatic build_frame(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                              input logic [15:0] dp, input logic [7:0] pr, input logic [15:0] etype);
      for (int i = 0; i < 128; i++) fb[i] = 8'(i) ^ 8'hA5;
      fb[12] = etype[15:8]; fb[13] = etype[7:0]; fb[14] = 8'h45;
      fb[20] = 8'h40; fb[21] = 8'h00; fb[23] = pr;
      fb[26] = sip[31:24]; fb[27] = sip[23:16]; fb[28] = sip[15:8]; fb[29] = sip[7:0];
      fb[30] = dip[31:24]; fb[31] = dip[23:16]; fb[32] = dip[15:8]; fb[33] = dip[7:0];
      fb[34] = sp[15:8]; fb[35] = sp[7:0]; fb[36] = dp[15:8]; fb[37] = dp[7:0];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tif.s_tvalid = 1'b0; tif.s_tlast = 1'b0; tif.tuple_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_beat(input int k, input int len, input bit last);
      for (int n = 0; n < 8; n++) begin
         tif.s_tdata[8*n +: 8] = fb[8*k+n];
         tif.s_tkeep[n] = (8*k + n) < len;
      end
      tif.s_tvalid = 1'b1; tif.s_tlast = last;
      @(posedge clk); #1;
      tif.s_tvalid = 1'b0; tif.s_tlast = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit gap, input bit pop4);
      int nb = (len + 7) / 8;
      for (int k = 0; k < nb; k++) begin
         if (pop4 && k == 4) tif.tuple_ready = 1'b1;
         send_beat(k, len, k == nb - 1);
         tif.tuple_ready = 1'b0;
         if (gap) begin
            tif.s_tdata = {$urandom, $urandom}; tif.s_tkeep = 8'h00; tif.s_tlast = 1'b1;
            @(posedge clk); #1;
            tif.s_tlast = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (tif.tuple_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tif.tuple_valid); end
      checks++; if (tif.tuple_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", tif.tuple_data); end
      checks++; if ({stat_pkts, stat_tuples, stat_skipped, stat_dropped} !== 128'h0) begin
         errors++; $display("FAIL reset_stats got %0d %0d %0d %0d want 0", stat_pkts, stat_tuples, stat_skipped, stat_dropped);
      end
   endtask

   task automatic test_tcp();
      logic [127:0] exp = {24'b0, 32'h0A000002, 32'h08080808, 16'h04D2, 16'h0050, 8'h06};
      do_reset();
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6, 16'h0800);
      for (int k = 0; k < 8; k++) begin
         send_beat(k, 64, k == 7);
         if (k == 3) begin
            checks++; if (tif.tuple_valid !== 1'b0) begin errors++; $display("FAIL tcp_early_valid got %b want 0", tif.tuple_valid); end
         end
         if (k == 4) begin
            checks++; if (tif.tuple_valid !== 1'b1) begin errors++; $display("FAIL tcp_latency got %b want 1", tif.tuple_valid); end
         end
      end
      checks++; if (tif.tuple_data !== exp) begin errors++; $display("FAIL tcp_tuple got %h want %h", tif.tuple_data, exp); end
      checks++; if (stat_tuples !== 32'd1 || stat_pkts !== 32'd1) begin
         errors++; $display("FAIL tcp_stats got tuples %0d pkts %0d want 1 1", stat_tuples, stat_pkts);
      end
      tif.tuple_ready = 1'b1; @(posedge clk); #1; tif.tuple_ready = 1'b0;
      checks++; if (tif.tuple_valid !== 1'b0) begin errors++; $display("FAIL tcp_pop got %b want 0", tif.tuple_valid); end
   endtask

   task automatic test_skip();
      do_reset();
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6, 16'h86DD);
      send_frame(64, 0, 0);
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd1, 16'h0800);
      send_frame(64, 0, 0);
      checks++; if (tif.tuple_valid !== 1'b0) begin errors++; $display("FAIL skip_valid got %b want 0", tif.tuple_valid); end
      checks++; if (stat_skipped !== 32'd2 || stat_pkts !== 32'd2) begin
         errors++; $display("FAIL skip_stats got skipped %0d pkts %0d want 2 2", stat_skipped, stat_pkts);
      end
      build_frame(32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'd17, 16'h0800);
      send_frame(37, 0, 0);
      checks++; if (stat_skipped !== 32'd3 || stat_pkts !== 32'd3 || stat_tuples !== 32'd0) begin
         errors++; $display("FAIL short_keep got skipped %0d pkts %0d tuples %0d want 3 3 0", stat_skipped, stat_pkts, stat_tuples);
      end
   endtask

   task automatic test_gaps();
      logic [127:0] exp = exp_tuple(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6);
      do_reset();
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6, 16'h0800);
      send_frame(64, 1, 0);
      checks++; if (tif.tuple_valid !== 1'b1 || tif.tuple_data !== exp) begin
         errors++; $display("FAIL gaps_tuple got %b %h want 1 %h", tif.tuple_valid, tif.tuple_data, exp);
      end
      checks++; if (stat_pkts !== 32'd1 || stat_skipped !== 32'd0) begin
         errors++; $display("FAIL gaps_stats got pkts %0d skipped %0d want 1 0", stat_pkts, stat_skipped);
      end
   endtask

   task automatic test_full();
      logic [127:0] exp;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         build_frame(32'hC0A80000 + 32'(i), 32'h0A0A0A0A, 16'(1000 + i), 16'd53, 8'd17, 16'h0800);
         send_frame(48, 0, 0);
      end
      checks++; if (stat_tuples !== 32'd4 || stat_dropped !== 32'd2) begin
         errors++; $display("FAIL full_stats got tuples %0d dropped %0d want 4 2", stat_tuples, stat_dropped);
      end
      for (int i = 0; i < 4; i++) begin
         exp = exp_tuple(32'hC0A80000 + 32'(i), 32'h0A0A0A0A, 16'(1000 + i), 16'd53, 8'd17);
         checks++; if (tif.tuple_valid !== 1'b1 || tif.tuple_data !== exp) begin
            errors++; $display("FAIL full_drain%0d got %b %h want 1 %h", i, tif.tuple_valid, tif.tuple_data, exp);
         end
         tif.tuple_ready = 1'b1; @(posedge clk); #1; tif.tuple_ready = 1'b0;
      end
      checks++; if (tif.tuple_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", tif.tuple_valid); end
   endtask

   task automatic test_full_pop();
      logic [127:0] exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         build_frame(32'h0B000000 + 32'(i), 32'h0C000001, 16'(2000 + i), 16'd443, 8'd6, 16'h0800);
         send_frame(40, 0, i == 4);
      end
      checks++; if (stat_tuples !== 32'd5 || stat_dropped !== 32'd0) begin
         errors++; $display("FAIL fullpop_stats got tuples %0d dropped %0d want 5 0", stat_tuples, stat_dropped);
      end
      for (int i = 1; i < 5; i++) begin
         exp = exp_tuple(32'h0B000000 + 32'(i), 32'h0C000001, 16'(2000 + i), 16'd443, 8'd6);
         checks++; if (tif.tuple_valid !== 1'b1 || tif.tuple_data !== exp) begin
            errors++; $display("FAIL fullpop_drain%0d got %b %h want 1 %h", i, tif.tuple_valid, tif.tuple_data, exp);
         end
         tif.tuple_ready = 1'b1; @(posedge clk); #1; tif.tuple_ready = 1'b0;
      end
   endtask

   task automatic test_runt();
      logic [127:0] exp = exp_tuple(32'hAC100001, 32'hAC100002, 16'd5000, 16'd6000, 8'd17);
      do_reset();
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6, 16'h0800);
      send_frame(24, 0, 0);
      build_frame(32'hAC100001, 32'hAC100002, 16'd5000, 16'd6000, 8'd17, 16'h0800);
      send_frame(60, 0, 0);
      checks++; if (stat_skipped !== 32'd1 || stat_pkts !== 32'd2 || stat_tuples !== 32'd1) begin
         errors++; $display("FAIL runt_stats got skipped %0d pkts %0d tuples %0d want 1 2 1", stat_skipped, stat_pkts, stat_tuples);
      end
      checks++; if (tif.tuple_valid !== 1'b1 || tif.tuple_data !== exp) begin
         errors++; $display("FAIL runt_next got %b %h want 1 %h", tif.tuple_valid, tif.tuple_data, exp);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp = exp_tuple(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6);
      do_reset();
      build_frame(32'h0A000002, 32'h08080808, 16'd1234, 16'd80, 8'd6, 16'h0800);
      for (int k = 0; k < 3; k++) send_beat(k, 64, 0);
      reset = 1'b1;
      send_beat(3, 64, 1);
      reset = 1'b0;
      checks++; if (tif.tuple_valid !== 1'b0 || {stat_pkts, stat_tuples, stat_skipped, stat_dropped} !== 128'h0) begin
         errors++; $display("FAIL midreset got valid %b stats %0d %0d %0d %0d want 0", tif.tuple_valid,
                            stat_pkts, stat_tuples, stat_skipped, stat_dropped);
      end
      send_frame(64, 0, 0);
      checks++; if (tif.tuple_valid !== 1'b1 || tif.tuple_data !== exp || stat_tuples !== 32'd1) begin
         errors++; $display("FAIL midreset_next got %b %h tuples %0d want 1 %h 1", tif.tuple_valid, tif.tuple_data, stat_tuples, exp);
      end
   endtask

   initial begin
      tif.s_tdata = '0; tif.s_tkeep = '0; tif.s_tvalid = 1'b0; tif.s_tlast = 1'b0; tif.tuple_ready = 1'b0;
      test_reset();
      test_tcp();
      test_skip();
      test_gaps();
      test_full();
      test_full_pop();
      test_runt();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
